// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory read bus between the fetch unit and imem.
//   imem_req   - read request, held until imem_ack
//   imem_addr  - word address of the read
//   imem_ack   - memory completes the read this cycle
//   imem_rdata - read data, valid with imem_req && imem_ack
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: multicycle MIPS instruction-fetch sequencer (PC, imem req/ack, IR).
//   clk, rst     - clock, synchronous active-high reset
//   fetch_start  - start a fetch at pc (ignored while busy)
//   redirect_en  - load redirect_pc as the next PC (deferred if mid-fetch)
//   redirect_pc  - branch/jump target, word address
//   imem         - instruction-memory read bus (master side)
//   pc, pc_plus1 - PC register and its combinational increment
//   ir, ir_valid - instruction register and its one-cycle update pulse
//   busy         - fetch in flight
//   fetch_count  - completed fetches, wrapping
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_start,
    input  logic                 redirect_en,
    input  logic [31:0]          redirect_pc,
    ifetch_unit_if.master        imem,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus1,
    output logic [31:0]          ir,
    output logic                 ir_valid,
    output logic                 busy,
    output logic [CNT_W-1:0]     fetch_count
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t      state, state_nx;
    logic        redirect_pend;
    logic [31:0] redirect_buf;
    logic        ack_now;
    always_comb begin
        state_nx = state;
        state_nx = (state == REQ) ? (imem.imem_ack ? DONE : REQ)
                                  : (fetch_start ? REQ : IDLE);
    end
    assign ack_now         = (state == REQ) && imem.imem_ack;
    assign pc_plus1        = pc + 32'd1;
    assign imem.imem_req   = (state == REQ);
    assign imem.imem_addr  = pc;
    assign busy            = (state == REQ);
    assign ir_valid        = (state == DONE);
    // pc only moves outside REQ or at the ack edge, keeping imem_addr stable
    // for the whole transaction; mid-fetch redirects are parked in redirect_buf.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            ir            <= 32'd0;
            fetch_count   <= '0;
            redirect_pend <= 1'b0;
            redirect_buf  <= 32'd0;
        end else begin
            state <= state_nx;
            if (ack_now) begin
                ir            <= imem.imem_rdata;
                fetch_count   <= fetch_count + CNT_W'(1);
                pc            <= redirect_en ? redirect_pc : redirect_pend ? redirect_buf : pc_plus1;
                redirect_pend <= 1'b0;
            end else if (state == REQ) begin
                if (redirect_en) begin
                    redirect_buf  <= redirect_pc;
                    redirect_pend <= 1'b1;
                end
            end else if (redirect_en) begin
                pc <= redirect_pc;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for ifetch_unit.
module tb_ifetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, fs, re;
    logic [31:0] rp;
    logic [31:0] pc, pcp, ir;
    logic        irv, busy;
    logic [15:0] cnt;
    ifetch_unit_if m0();

    logic        rst1, fs1, re1;
    logic [31:0] rp1;
    logic [31:0] pc1, pcp1, ir1;
    logic        irv1, busy1;
    logic [1:0]  cnt1;
    ifetch_unit_if m1();

    ifetch_unit u0 (
        .clk(clk), .rst(rst), .fetch_start(fs), .redirect_en(re), .redirect_pc(rp),
        .imem(m0), .pc(pc), .pc_plus1(pcp), .ir(ir), .ir_valid(irv),
        .busy(busy), .fetch_count(cnt)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFFF), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst1), .fetch_start(fs1), .redirect_en(re1), .redirect_pc(rp1),
        .imem(m1), .pc(pc1), .pc_plus1(pcp1), .ir(ir1), .ir_valid(irv1),
        .busy(busy1), .fetch_count(cnt1)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; fs = 0; re = 0; rp = 0;
        m0.imem_ack = 0; m0.imem_rdata = 0;
        rst1 = 1; fs1 = 0; re1 = 0; rp1 = 0;
        m1.imem_ack = 0; m1.imem_rdata = 0;
        tick; tick;
        rst = 0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_irv", 32'(irv), 32'h0);
        chk("rst_req", 32'(m0.imem_req), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnt", 32'(cnt), 32'h0);

        // single fetch, zero wait
        fs = 1; tick; fs = 0;
        chk("f1_req", 32'(m0.imem_req), 32'h1);
        chk("f1_addr", m0.imem_addr, 32'h0);
        m0.imem_ack = 1; m0.imem_rdata = 32'h2008_0005;
        tick; m0.imem_ack = 0;
        chk("f1_ir", ir, 32'h2008_0005);
        chk("f1_irv", 32'(irv), 32'h1);
        chk("f1_pc", pc, 32'h1);
        chk("f1_pcp", pcp, 32'h2);
        chk("f1_cnt", 32'(cnt), 32'h1);
        chk("f1_req_done", 32'(m0.imem_req), 32'h0);
        tick;
        chk("f1_irv_pulse", 32'(irv), 32'h0);

        // redirect in IDLE to 4
        re = 1; rp = 32'h4; tick; re = 0;
        chk("idle_redir_pc", pc, 32'h4);

        // wait states: ack after 3 wait cycles; fetch_start in REQ ignored
        fs = 1; tick; fs = 0;
        for (int i = 0; i < 3; i++) begin
            chk("ws_req", 32'(m0.imem_req), 32'h1);
            chk("ws_addr", m0.imem_addr, 32'h4);
            chk("ws_busy", 32'(busy), 32'h1);
            chk("ws_pc", pc, 32'h4);
            fs = (i == 1);
            tick;
        end
        fs = 0;
        chk("ws_req4", 32'(m0.imem_req), 32'h1);
        chk("ws_addr4", m0.imem_addr, 32'h4);
        m0.imem_ack = 1; m0.imem_rdata = 32'h1234_5678;
        tick; m0.imem_ack = 0;
        chk("ws_pc_after", pc, 32'h5);
        chk("ws_ir", ir, 32'h1234_5678);
        chk("ws_cnt", 32'(cnt), 32'h2);
        tick;
        chk("ws_idle_busy", 32'(busy), 32'h0);
        chk("ws_idle_req", 32'(m0.imem_req), 32'h0);

        // redirects during REQ
        re = 1; rp = 32'h8; tick; re = 0;
        fs = 1; tick; fs = 0;
        re = 1; rp = 32'h40; tick;
        chk("rr_addr_a", m0.imem_addr, 32'h8);
        chk("rr_pc_a", pc, 32'h8);
        rp = 32'h80; tick; re = 0;
        chk("rr_addr_b", m0.imem_addr, 32'h8);
        m0.imem_ack = 1; m0.imem_rdata = 32'hAAAA_0001;
        tick; m0.imem_ack = 0;
        chk("rr_pc", pc, 32'h80);
        chk("rr_cnt", 32'(cnt), 32'h3);
        // back-to-back fetch from DONE
        fs = 1; tick; fs = 0;
        chk("b2b_req", 32'(m0.imem_req), 32'h1);
        chk("b2b_addr", m0.imem_addr, 32'h80);
        m0.imem_ack = 1; m0.imem_rdata = 32'hBBBB_0002;
        tick; m0.imem_ack = 0;
        chk("b2b_pc", pc, 32'h81);
        chk("b2b_ir", ir, 32'hBBBB_0002);
        chk("b2b_cnt", 32'(cnt), 32'h4);
        tick;

        // redirect and fetch_start together in IDLE
        re = 1; rp = 32'h100; fs = 1; tick; re = 0; fs = 0;
        chk("rf_addr", m0.imem_addr, 32'h100);
        chk("rf_req", 32'(m0.imem_req), 32'h1);
        m0.imem_ack = 1; m0.imem_rdata = 32'hCCCC_0003;
        tick; m0.imem_ack = 0;
        chk("rf_pc", pc, 32'h101);
        chk("rf_cnt", 32'(cnt), 32'h5);
        tick;

        // redirect in the ack cycle beats a pending one
        fs = 1; tick; fs = 0;
        re = 1; rp = 32'h300; tick;
        rp = 32'h200; m0.imem_ack = 1; m0.imem_rdata = 32'hDDDD_0004;
        tick; re = 0; m0.imem_ack = 0;
        chk("ackredir_pc", pc, 32'h200);
        tick;
        // pending redirect must have been cleared by that ack
        fs = 1; tick; fs = 0;
        m0.imem_ack = 1; tick; m0.imem_ack = 0;
        chk("pend_clr_pc", pc, 32'h201);
        tick;

        // reset mid-handshake with a late ack
        fs = 1; tick; fs = 0;
        chk("mr_busy_pre", 32'(busy), 32'h1);
        rst = 1; tick; rst = 0;
        m0.imem_ack = 1; m0.imem_rdata = 32'hDEAD_BEEF;
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_req", 32'(m0.imem_req), 32'h0);
        chk("mr_pc", pc, 32'h0);
        chk("mr_ir", ir, 32'h0);
        chk("mr_cnt", 32'(cnt), 32'h0);
        chk("mr_irv", 32'(irv), 32'h0);
        tick; m0.imem_ack = 0;
        chk("mr_irv2", 32'(irv), 32'h0);
        chk("mr_ir2", ir, 32'h0);
        chk("mr_cnt2", 32'(cnt), 32'h0);
        chk("mr_pc2", pc, 32'h0);

        // wrap-around instance: RESET_PC = FFFF_FFFF, CNT_W = 2
        rst1 = 0;
        chk("w_rst_pc", pc1, 32'hFFFF_FFFF);
        chk("w_rst_pcp", pcp1, 32'h0);
        fs1 = 1; tick; fs1 = 0;
        chk("w_addr", m1.imem_addr, 32'hFFFF_FFFF);
        m1.imem_ack = 1; m1.imem_rdata = 32'h1;
        tick;
        chk("w_pc", pc1, 32'h0);
        chk("w_pcp", pcp1, 32'h1);
        chk("w_cnt1", 32'(cnt1), 32'h1);
        for (int i = 0; i < 4; i++) begin
            fs1 = 1; tick; fs1 = 0; tick;
        end
        m1.imem_ack = 0;
        chk("w_cnt5", 32'(cnt1), 32'h1);
        chk("w_pc5", pc1, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
